// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch/decode/execute
// phases, ALU-control and immediate decode, and a retired-instruction counter.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  output logic        pcWrite,
  output logic        adrSrc,
  output logic        irWrite,
  output logic        memWrite,
  output logic        regWrite,
  output logic [1:0]  resSrc,
  output logic [1:0]  aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  immSrc,
  output logic [2:0]  ALUcontrol,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, JAL, BEQ
  } state_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} alu_op_t;

  state_t      state, state_next;
  alu_op_t     alu_op;
  logic        pc_update, branch, retire;
  logic        adr_src_raw, ir_write_raw, mem_write_raw, reg_write_raw, illegal_raw;
  logic [1:0]  res_src_raw, src_a_raw, src_b_raw, imm_src_raw;
  logic [2:0]  alu_ctrl_raw;
  logic [31:0] instret_q;

  // State register; reset lands in FETCH so the first released edge fetches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  // Next-state and Moore control decode; every signal defaults to inactive.
  always_comb begin
    state_next    = FETCH;
    pc_update     = 1'b0;
    branch        = 1'b0;
    retire        = 1'b0;
    adr_src_raw   = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    res_src_raw   = 2'b00;
    src_a_raw     = 2'b00;
    src_b_raw     = 2'b00;
    alu_op        = ALU_ADD;
    case (state)
      FETCH: begin
        state_next   = DECODE;
        ir_write_raw = 1'b1;
        pc_update    = 1'b1;
        src_b_raw    = 2'b10;
        res_src_raw  = 2'b10;
      end
      DECODE: begin
        src_a_raw = 2'b01;
        src_b_raw = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTER;
          OP_I:         state_next = EXECUTEI;
          OP_JAL:       state_next = JAL;
          OP_BEQ:       state_next = BEQ;
          default: begin
            state_next  = FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
        src_a_raw  = 2'b10;
        src_b_raw  = 2'b01;
      end
      MEMREAD: begin
        state_next  = MEMWB;
        adr_src_raw = 1'b1;
      end
      MEMWB: begin
        retire        = 1'b1;
        res_src_raw   = 2'b01;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        retire        = 1'b1;
        adr_src_raw   = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECUTER: begin
        state_next = ALUWB;
        src_a_raw  = 2'b10;
        alu_op     = ALU_FUNCT;
      end
      EXECUTEI: begin
        state_next = ALUWB;
        src_a_raw  = 2'b10;
        src_b_raw  = 2'b01;
        alu_op     = ALU_FUNCT;
      end
      ALUWB: begin
        retire        = 1'b1;
        reg_write_raw = 1'b1;
      end
      JAL: begin
        state_next = ALUWB;
        src_a_raw  = 2'b01;
        src_b_raw  = 2'b10;
        pc_update  = 1'b1;
      end
      BEQ: begin
        retire    = 1'b1;
        src_a_raw = 2'b10;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  // ALU control: fixed add/sub, or decoded from funct3 (sub only for R-type with funct7b5).
  always_comb begin
    alu_ctrl_raw = 3'b000;
    case (alu_op)
      ALU_SUB: alu_ctrl_raw = 3'b001;
      ALU_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl_raw = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl_raw = 3'b101;
          3'b110:  alu_ctrl_raw = 3'b011;
          3'b111:  alu_ctrl_raw = 3'b010;
          default: alu_ctrl_raw = 3'b000;
        endcase
      end
      default: alu_ctrl_raw = 3'b000;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (op)
      OP_SW:   imm_src_raw = 2'b01;
      OP_BEQ:  imm_src_raw = 2'b10;
      OP_JAL:  imm_src_raw = 2'b11;
      default: imm_src_raw = 2'b00;
    endcase
  end

  // Output stage: everything held inactive while reset is low, since the
  // FETCH state would otherwise drive irWrite/pcWrite during reset.
  always_comb begin
    pcWrite    = 1'b0;
    adrSrc     = 1'b0;
    irWrite    = 1'b0;
    memWrite   = 1'b0;
    regWrite   = 1'b0;
    illegal    = 1'b0;
    resSrc     = 2'b00;
    aluSrcA    = 2'b00;
    aluSrcB    = 2'b00;
    immSrc     = 2'b00;
    ALUcontrol = 3'b000;
    if (reset) begin
      pcWrite    = pc_update | (branch & zero);
      adrSrc     = adr_src_raw;
      irWrite    = ir_write_raw;
      memWrite   = mem_write_raw;
      regWrite   = reg_write_raw;
      illegal    = illegal_raw;
      resSrc     = res_src_raw;
      aluSrcA    = src_a_raw;
      aluSrcB    = src_b_raw;
      immSrc     = imm_src_raw;
      ALUcontrol = alu_ctrl_raw;
    end
  end

  // Retired-instruction counter, bumped on each completing transition back to FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      instret_q <= '0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model compared
// every cycle, plus directed literal expectations.
module tb_multicycle_control;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] JALO = 7'b1101111;
  localparam logic [6:0] BEQO = 7'b1100011;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  op = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        funct7b5 = 1'b0;
  logic        zero = 1'b0;
  logic        pcWrite, adrSrc, irWrite, memWrite, regWrite, illegal;
  logic [1:0]  resSrc, aluSrcA, aluSrcB, immSrc;
  logic [2:0]  ALUcontrol;
  logic [31:0] instret;

  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  bit          preset_req = 1'b0;
  int          step = 0;
  int          cur_cls;
  logic [31:0] mcount = 32'd0;
  logic [16:0] exp_vec, act_vec;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pcWrite(pcWrite), .adrSrc(adrSrc), .irWrite(irWrite),
    .memWrite(memWrite), .regWrite(regWrite), .resSrc(resSrc),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .immSrc(immSrc),
    .ALUcontrol(ALUcontrol), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction class: 0 lw, 1 sw, 2 R, 3 addi, 4 jal, 5 beq, 6 unsupported
  function automatic int cls_of(input logic [6:0] o);
    case (o)
      LW:      return 0;
      SW:      return 1;
      RT:      return 2;
      IT:      return 3;
      JALO:    return 4;
      BEQO:    return 5;
      default: return 6;
    endcase
  endfunction

  // Cycles per instruction (unsupported ones spend FETCH + DECODE)
  function automatic int len_of(input int c);
    case (c)
      0:          return 5;
      1, 2, 3, 4: return 4;
      5:          return 3;
      default:    return 2;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for a given cycle index within an instruction
  // {pcWrite,adrSrc,irWrite,memWrite,regWrite,resSrc,aluSrcA,aluSrcB,immSrc,ALUcontrol,illegal}
  function automatic logic [16:0] expected(input logic rst, input int st, input logic [6:0] o,
                                           input logic [2:0] f3, input logic f7, input logic z);
    logic pw = 0, ad = 0, ir = 0, mw = 0, rw = 0, il = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, im = 0;
    logic [2:0] ac = 0;
    int c;
    if (!rst) return 17'd0;
    c = cls_of(o);
    im = (c == 1) ? 2'b01 : (c == 5) ? 2'b10 : (c == 4) ? 2'b11 : 2'b00;
    if (st == 0) begin
      ir = 1; pw = 1; sb = 2'b10; rs = 2'b10;
    end else if (st == 1) begin
      sa = 2'b01; sb = 2'b01; il = (c == 6);
    end else if (st == 2) begin
      case (c)
        0, 1: begin sa = 2'b10; sb = 2'b01; end
        2:    begin sa = 2'b10; ac = funct_alu(o, f3, f7); end
        3:    begin sa = 2'b10; sb = 2'b01; ac = funct_alu(o, f3, f7); end
        4:    begin sa = 2'b01; sb = 2'b10; pw = 1; end
        5:    begin sa = 2'b10; ac = 3'b001; pw = z; end
        default: ;
      endcase
    end else if (st == 3) begin
      case (c)
        0:       ad = 1;
        1:       begin ad = 1; mw = 1; end
        default: rw = 1;
      endcase
    end else begin
      rs = 2'b01; rw = 1;
    end
    return {pw, ad, ir, mw, rw, rs, sa, sb, im, ac, il};
  endfunction

  // Reference model: cycle index within the current instruction and retire count
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      step   = 0;
      mcount = 32'd0;
    end else begin
      cur_cls = cls_of(op);
      if (step >= len_of(cur_cls) - 1) begin
        step = 0;
        if (cur_cls != 6) mcount = mcount + 32'd1;
      end else begin
        step = step + 1;
      end
      if (preset_req) mcount = 32'hFFFF_FFFF;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      exp_vec = expected(reset, step, op, funct3, funct7b5, zero);
      act_vec = {pcWrite, adrSrc, irWrite, memWrite, regWrite, resSrc, aluSrcA, aluSrcB,
                 immSrc, ALUcontrol, illegal};
      check($sformatf("outputs step%0d op%b", step, op), 32'(act_vec), 32'(exp_vec));
      if (!preset_req) check("instret", instret, mcount);
    end
  end

  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                     input int n, input int probe, output logic pw, output logic [2:0] ac,
                     output logic il, output logic rw);
    pw = 0; ac = 0; il = 0; rw = 0;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == probe) begin
        pw = pcWrite; ac = ALUcontrol; il = illegal; rw = regWrite;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic pw, il, rw;
    logic [2:0] ac;
    chk_en = 1'b1;
    op = LW;

    // Held in reset: everything inactive
    @(negedge clk);
    check("rst_irWrite", 32'(irWrite), 32'd0);
    check("rst_pcWrite", 32'(pcWrite), 32'd0);
    check("rst_aluSrcB", 32'(aluSrcB), 32'd0);
    check("rst_resSrc", 32'(resSrc), 32'd0);
    check("rst_instret", instret, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // lw: five cycles, writeback only in the last
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) check("first_fetch", 32'({irWrite, pcWrite}), 32'd3);
      check($sformatf("lw_regWrite_c%0d", i + 1), 32'(regWrite), 32'(i == 4));
      check($sformatf("lw_resSrc01_c%0d", i + 1), 32'(resSrc == 2'b01), 32'(i == 4));
      @(posedge clk);
      #1;
    end
    check("lw_instret", instret, 32'd1);

    run(SW, 3'b010, 1'b0, 1'b0, 4, 3, pw, ac, il, rw);
    run(RT, 3'b000, 1'b1, 1'b0, 4, 2, pw, ac, il, rw);
    check("r_sub_alu", 32'(ac), 32'd1);
    run(RT, 3'b000, 1'b0, 1'b0, 4, 2, pw, ac, il, rw);
    check("r_add_alu", 32'(ac), 32'd0);
    run(RT, 3'b110, 1'b0, 1'b0, 4, 2, pw, ac, il, rw);
    check("r_or_alu", 32'(ac), 32'd3);
    run(RT, 3'b111, 1'b0, 1'b0, 4, 2, pw, ac, il, rw);
    check("r_and_alu", 32'(ac), 32'd2);
    run(RT, 3'b010, 1'b0, 1'b0, 4, 2, pw, ac, il, rw);
    check("r_slt_alu", 32'(ac), 32'd5);
    run(IT, 3'b000, 1'b1, 1'b0, 4, 2, pw, ac, il, rw);
    check("addi_f7_alu", 32'(ac), 32'd0);
    run(IT, 3'b100, 1'b0, 1'b0, 4, 3, pw, ac, il, rw);
    check("addi_wb", 32'(rw), 32'd1);
    run(JALO, 3'b000, 1'b0, 1'b0, 4, 2, pw, ac, il, rw);
    check("jal_pcWrite", 32'(pw), 32'd1);
    run(BEQO, 3'b000, 1'b0, 1'b1, 3, 2, pw, ac, il, rw);
    check("beq_taken_pcWrite", 32'(pw), 32'd1);
    check("beq_taken_alu", 32'(ac), 32'd1);
    run(BEQO, 3'b000, 1'b0, 1'b0, 3, 2, pw, ac, il, rw);
    check("beq_nt_pcWrite", 32'(pw), 32'd0);
    check("instret_12", instret, 32'd12);

    run(7'b0000000, 3'b000, 1'b0, 1'b0, 2, 1, pw, ac, il, rw);
    check("illegal_decode", 32'(il), 32'd1);
    check("illegal_no_count", instret, 32'd12);

    // Counter wrap: preload all-ones during the FETCH of an sw
    op = SW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    preset_req = 1'b1;
    force dut.instret_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.instret_q;
    preset_req = 1'b0;
    check("preset_hold", instret, 32'hFFFF_FFFF);
    run(SW, 3'b010, 1'b0, 1'b0, 3, 2, pw, ac, il, rw);
    check("instret_wrap", instret, 32'd0);

    // Reset in the middle of a load
    run(IT, 3'b000, 1'b0, 1'b0, 4, 0, pw, ac, il, rw);
    run(LW, 3'b010, 1'b0, 1'b0, 3, 0, pw, ac, il, rw);
    #1 reset = 1'b0;
    #1;
    check("midrst_adrSrc", 32'(adrSrc), 32'd0);
    check("midrst_memWrite", 32'(memWrite), 32'd0);
    check("midrst_regWrite", 32'(regWrite), 32'd0);
    check("midrst_irWrite", 32'(irWrite), 32'd0);
    check("midrst_instret", instret, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run(LW, 3'b010, 1'b0, 1'b0, 5, 4, pw, ac, il, rw);
    check("lw_restart_wb", 32'(rw), 32'd1);
    check("lw_restart_instret", instret, 32'd1);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
